// File: rtl/lut_sweep_capture.sv
// Sequential truth-table reader for one combinational LUT neuron: sweeps every
// input code, packs the sampled output bits into words and streams them out.
// Optional build macro LUT_SWEEP_POPCOUNT_EN appends a popcount word to the stream.
module lut_sweep_capture #(
  parameter int IN_BITS   = 8,
  parameter int WORD_W    = 32,
  parameter int PROBE_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [IN_BITS-1:0] probe_addr,
  input  logic               probe_data,
  output logic [WORD_W-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic [2:0]         dbg_state
);

  // Output handshake: a word transfers on a rising clk edge where out_valid and
  // out_ready are both high; out_data/out_last hold while out_valid && !out_ready.

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_HOLD = 3'd2;
  localparam logic [2:0] S_EMIT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_POP  = 3'd5;

  localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [IN_BITS:0] LAST_K = (IN_BITS+1)'((1 << IN_BITS) - 1);
  localparam logic [IN_BITS:0] K_ONE  = (IN_BITS+1)'(1);
  localparam logic [BW-1:0]    POS_FULL = BW'(WORD_W - 1);
  localparam logic [3:0]       LAT_END  = 4'(PROBE_LAT - 1);

  logic [2:0]         state;
  logic [IN_BITS:0]   k;
  logic [3:0]         lat_cnt;
  logic [WORD_W-1:0]  shreg;
  logic [IN_BITS-1:0] k_rev;
  logic [BW-1:0]      pos;

`ifdef LUT_SWEEP_POPCOUNT_EN
  logic [IN_BITS:0]   pop_cnt;
`endif

  // probe_addr is the bit-reversed index so M0[MSB] toggles fastest.
  always_comb begin
    k_rev = '0;
    for (int i = 0; i < IN_BITS; i++) k_rev[IN_BITS-1-i] = k[i];
  end

  assign pos = k[BW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      k          <= '0;
      lat_cnt    <= '0;
      shreg      <= '0;
      probe_addr <= '0;
`ifdef LUT_SWEEP_POPCOUNT_EN
      pop_cnt    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_LOAD;
            k     <= '0;
            shreg <= '0;
`ifdef LUT_SWEEP_POPCOUNT_EN
            pop_cnt <= '0;
`endif
          end
        end
        S_LOAD: begin
          probe_addr <= k_rev;
          lat_cnt    <= '0;
          state      <= S_HOLD;
        end
        S_HOLD: begin
          if (lat_cnt == LAT_END) begin
            shreg[pos] <= probe_data;
`ifdef LUT_SWEEP_POPCOUNT_EN
            pop_cnt <= pop_cnt + {{IN_BITS{1'b0}}, probe_data};
`endif
            if (pos == POS_FULL) begin
              state <= S_EMIT;
            end else begin
              k     <= k + K_ONE;
              state <= S_LOAD;
            end
          end else begin
            lat_cnt <= lat_cnt + 4'd1;
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            shreg <= '0;
            if (k == LAST_K) begin
`ifdef LUT_SWEEP_POPCOUNT_EN
              state <= S_POP;
`else
              state <= S_DONE;
`endif
            end else begin
              k     <= k + K_ONE;
              state <= S_LOAD;
            end
          end
        end
`ifdef LUT_SWEEP_POPCOUNT_EN
        S_POP: begin
          if (out_ready) state <= S_DONE;
        end
`endif
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign dbg_state = state;
  assign done      = (state == S_DONE);

`ifdef LUT_SWEEP_POPCOUNT_EN
  assign busy      = (state == S_LOAD) || (state == S_HOLD) || (state == S_EMIT) || (state == S_POP);
  assign out_valid = (state == S_EMIT) || (state == S_POP);
  assign out_last  = (state == S_POP);
  assign out_data  = (state == S_POP) ? WORD_W'(pop_cnt) : shreg;
`else
  assign busy      = (state == S_LOAD) || (state == S_HOLD) || (state == S_EMIT);
  assign out_valid = (state == S_EMIT);
  assign out_last  = (state == S_EMIT) && (k == LAST_K);
  assign out_data  = shreg;
`endif

endmodule
